// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: architectural PC register and instruction fetch sequencer.
// Holds the PC, issues fetches to instruction memory, advances by 4 per
// completed fetch, loads redirect targets and flags misaligned targets.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        misalign_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state, state_n;
    logic [31:0] pc_n, inst_out_n, inst_pc_n;
    logic        inst_valid_n, misalign_n;

    // Request and address are decoded, so an async reset drops the request at once.
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc_out;

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= BOOT;
        else       state <= state_n;
    end

    // Next-state and next-value decode; redirect overrides everything.
    always_comb begin
        state_n      = state;
        pc_n         = pc_out;
        inst_out_n   = inst_out;
        inst_pc_n    = inst_pc;
        inst_valid_n = inst_valid;
        misalign_n   = misalign_err;
        if (redirect_valid) begin
            // Flush: any same-cycle memory response is dropped and PC does not step.
            pc_n         = redirect_target;
            inst_valid_n = 1'b0;
            if (redirect_target[1:0] == 2'b00) begin
                state_n    = FETCH;
                misalign_n = 1'b0;
            end else begin
                state_n    = ERR;
                misalign_n = 1'b1;
            end
        end else begin
            case (state)
                BOOT: state_n = FETCH;
                FETCH: begin
                    if (imem_ready) begin
                        inst_out_n   = imem_rdata;
                        inst_pc_n    = pc_out;
                        inst_valid_n = 1'b1;
                        pc_n         = pc_out + 32'd4;
                        state_n      = stall ? HOLD : FETCH;
                    end else if (!stall) begin
                        // Current instruction accepted, nothing new arrived.
                        inst_valid_n = 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        inst_valid_n = 1'b0;
                        state_n      = FETCH;
                    end
                end
                ERR: inst_valid_n = 1'b0;
                default: state_n = BOOT;
            endcase
        end
    end

    // Architectural PC and fetched-instruction output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_out       <= RESET_PC;
            inst_out     <= 32'd0;
            inst_pc      <= 32'd0;
            inst_valid   <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            pc_out       <= pc_n;
            inst_out     <= inst_out_n;
            inst_pc      <= inst_pc_n;
            inst_valid   <= inst_valid_n;
            misalign_err <= misalign_n;
        end
    end

endmodule
